vector_mac_pe: RTL and testbench

- Parametrised successor to the single-lane serial MAC PE: LANES signed neuron×weight products per beat, reduced by a registered adder tree and accumulated into a wide partial sum.
- Adds valid/ready backpressure on both sides, a configurable accumulator width and a held result register.
- Sits between the neuron/weight buffers and the output buffer in the PE array; one instance per output channel.

---
 rtl/vector_mac_pkg.sv | 16 +
 rtl/pe_adder_tree.sv | 31 +++
 rtl/vector_mac_pe.sv | 146 ++++++++++++++
 tb/tb_vector_mac_pe.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vector_mac_pkg.sv
// Shared constants and width helpers for the vector MAC processing element.
package vector_mac_pkg;

  localparam int CTL_FIRST = 0;
  localparam int CTL_LAST  = 1;

  // Width of the full-precision sum of 'lanes' products of two data_w operands.
  function automatic int tree_sum_w(input int data_w, input int lanes);
    return 2 * data_w + $clog2(lanes);
  endfunction

  function automatic int max_w(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pe_adder_tree.sv
// Combinational signed reduction of LANES full-precision products; the caller registers the sum.
module pe_adder_tree
  import vector_mac_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int DATA_W = 16
) (
  input  logic [LANES*2*DATA_W-1:0]                i_prod,
  output logic signed [tree_sum_w(DATA_W, LANES)-1:0] o_sum
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int SUM_W  = tree_sum_w(DATA_W, LANES);
  localparam int NODES  = 2 * LANES - 1;

  // Heap-ordered binary tree: leaves at LANES-1.., root at node 0.
  always_comb begin : p_tree
    logic signed [SUM_W-1:0] node [NODES];
    for (int n = 0; n < NODES; n++) begin
      node[n] = '0;
    end
    for (int i = 0; i < LANES; i++) begin
      node[LANES-1+i] = SUM_W'($signed(i_prod[i*PROD_W +: PROD_W]));
    end
    for (int k = LANES - 2; k >= 0; k--) begin
      node[k] = node[2*k+1] + node[2*k+2];
    end
    o_sum = node[0];
  end

endmodule

// File: rtl/vector_mac_pe.sv
// LANES-wide signed MAC: products -> adder tree -> accumulate, 3 stages, whole pipe freezes on output stall.
// Define VECTOR_MAC_PE_SAT_EN for saturating accumulation with a sticky sat_o; otherwise it wraps.
module vector_mac_pe
  import vector_mac_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [LANES*DATA_W-1:0] neuron,
  input  logic [LANES*DATA_W-1:0] weight,
  input  logic [1:0]              ctl,
  input  logic                    vld_i,
  output logic                    rdy_i,
  output logic [ACC_W-1:0]        result,
  output logic                    vld_o,
  input  logic                    rdy_o,
  output logic                    sat_o
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int SUM_W  = tree_sum_w(DATA_W, LANES);
`ifdef VECTOR_MAC_PE_SAT_EN
  // Keep the tree sum exact so an overflowing beat clamps instead of aliasing.
  localparam int S2_W = max_w(ACC_W, SUM_W);
`else
  localparam int S2_W = ACC_W;
`endif

  logic                      w_stall;
  logic [LANES*PROD_W-1:0]   w_prod;
  logic signed [SUM_W-1:0]   w_tree_sum;
  logic                      w_first;
  logic                      w_last;
  logic signed [ACC_W-1:0]   w_base;
  logic signed [ACC_W-1:0]   w_psum_nxt;

  logic                      r_s1_vld;
  logic [1:0]                r_s1_ctl;
  logic [LANES*PROD_W-1:0]   r_s1_prod;
  logic                      r_s2_vld;
  logic [1:0]                r_s2_ctl;
  logic signed [S2_W-1:0]    r_s2_sum;
  logic signed [ACC_W-1:0]   r_psum;
  logic signed [ACC_W-1:0]   r_result;
  logic                      r_vld_o;

  assign w_stall = r_vld_o && !rdy_o;
  assign rdy_i   = !w_stall;
  assign vld_o   = r_vld_o;
  assign result  = r_result;

  always_comb begin
    w_prod = '0;
    for (int i = 0; i < LANES; i++) begin
      w_prod[i*PROD_W +: PROD_W] = PROD_W'($signed(neuron[i*DATA_W +: DATA_W]))
                                 * PROD_W'($signed(weight[i*DATA_W +: DATA_W]));
    end
  end

  pe_adder_tree #(
    .LANES  (LANES),
    .DATA_W (DATA_W)
  ) u_tree (
    .i_prod (r_s1_prod),
    .o_sum  (w_tree_sum)
  );

  assign w_first = r_s2_ctl[CTL_FIRST];
  assign w_last  = r_s2_ctl[CTL_LAST];
  assign w_base  = w_first ? '0 : r_psum;

`ifdef VECTOR_MAC_PE_SAT_EN
  logic signed [S2_W:0]      w_wide;
  logic [S2_W-ACC_W+1:0]     w_hi;
  logic                      w_ovf;
  logic                      w_sat_nxt;
  logic                      r_sat;
  logic                      r_sat_o;

  // Overflow when the bits above the ACC_W sign bit are not a pure sign extension.
  always_comb begin
    w_wide = (S2_W+1)'(w_base) + (S2_W+1)'(r_s2_sum);
    w_hi   = w_wide[S2_W:ACC_W-1];
    w_ovf  = !((&w_hi) || !(|w_hi));
    if (!w_ovf) begin
      w_psum_nxt = w_wide[ACC_W-1:0];
    end else if (w_wide[S2_W]) begin
      w_psum_nxt = {1'b1, {(ACC_W-1){1'b0}}};
    end else begin
      w_psum_nxt = {1'b0, {(ACC_W-1){1'b1}}};
    end
    w_sat_nxt = (r_sat && !w_first) || w_ovf;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sat   <= 1'b0;
      r_sat_o <= 1'b0;
    end else if (!w_stall && r_s2_vld) begin
      r_sat <= w_sat_nxt;
      if (w_last) begin
        r_sat_o <= w_sat_nxt;
      end
    end
  end

  assign sat_o = r_sat_o;
`else
  assign w_psum_nxt = w_base + r_s2_sum;
  assign sat_o      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_vld <= 1'b0;
      r_s2_vld <= 1'b0;
      r_psum   <= '0;
      r_result <= '0;
      r_vld_o  <= 1'b0;
    end else if (!w_stall) begin
      r_s1_vld <= vld_i;
      r_s2_vld <= r_s1_vld;
      if (r_s2_vld) begin
        r_psum <= w_psum_nxt;
      end
      if (r_s2_vld && w_last) begin
        r_result <= w_psum_nxt;
      end
      // Unstalled means either idle or the held result is being taken now.
      r_vld_o <= r_s2_vld && w_last;
    end
  end

  always_ff @(posedge clk) begin
    if (!w_stall) begin
      r_s1_ctl  <= ctl;
      r_s1_prod <= w_prod;
      r_s2_ctl  <= r_s1_ctl;
      r_s2_sum  <= S2_W'(w_tree_sum);
    end
  end

endmodule

// File: tb/tb_vector_mac_pe.sv
// Randomised and directed checks of vector_mac_pe against a dot-product/accumulator reference model.
module tb_vector_mac_pe;

  localparam int LANES = 4;
  localparam int DW    = 16;
  localparam int AW    = 32;
  localparam int BW    = LANES * DW;
  localparam longint MAXV = (longint'(1) << (AW - 1)) - 1;
  localparam longint MINV = -(longint'(1) << (AW - 1));

  logic          clk    = 1'b0;
  logic          rst    = 1'b1;
  logic [BW-1:0] neuron = '0;
  logic [BW-1:0] weight = '0;
  logic [1:0]    ctl    = 2'b00;
  logic          vld_i  = 1'b0;
  logic          rdy_o  = 1'b1;
  logic          rdy_i;
  logic          vld_o;
  logic          sat_o;
  logic [AW-1:0] result;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int rdy_mode = 0;  // 0: always ready, 1: hold off, 2: random

  longint     m_acc = 0;
  bit         m_sat = 1'b0;
  logic [AW:0] exp_q[$];
  logic [AW:0] got_q[$];
  int          got_cyc[$];

  vector_mac_pe #(
    .LANES  (LANES),
    .DATA_W (DW),
    .ACC_W  (AW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .neuron (neuron),
    .weight (weight),
    .ctl    (ctl),
    .vld_i  (vld_i),
    .rdy_i  (rdy_i),
    .result (result),
    .vld_o  (vld_o),
    .rdy_o  (rdy_o),
    .sat_o  (sat_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0:       rdy_o = 1'b1;
      1:       rdy_o = 1'b0;
      default: rdy_o = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Record every result transfer; the edge following this negedge completes it.
  always @(negedge clk) begin
    if (!rst && vld_o && rdy_o) begin
      got_q.push_back({result, sat_o});
      got_cyc.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [BW-1:0] splat(input int v);
    logic [BW-1:0] r;
    logic [31:0]   t;
    t = v;
    for (int i = 0; i < LANES; i++) r[i*DW +: DW] = t[DW-1:0];
    return r;
  endfunction

  function automatic logic [AW:0] got_at(input int i);
    if (i < got_q.size()) return got_q[i];
    return 'x;
  endfunction

  // Reference: dot product of the beat, then accumulate exactly and wrap or clamp.
  task automatic apply_model(input logic [BW-1:0] n, input logic [BW-1:0] w, input logic [1:0] c);
    longint dot;
    longint t;
    logic signed [AW-1:0] tr;
    dot = 0;
    for (int i = 0; i < LANES; i++)
      dot += longint'($signed(n[i*DW +: DW])) * longint'($signed(w[i*DW +: DW]));
    if (c[0]) begin
      m_acc = 0;
      m_sat = 1'b0;
    end
    t = m_acc + dot;
`ifdef VECTOR_MAC_PE_SAT_EN
    if (t > MAXV) begin
      t = MAXV;
      m_sat = 1'b1;
    end else if (t < MINV) begin
      t = MINV;
      m_sat = 1'b1;
    end
    m_acc = t;
`else
    tr = t[AW-1:0];
    m_acc = longint'(tr);
`endif
    if (c[1]) exp_q.push_back({m_acc[AW-1:0], m_sat});
  endtask

  // Called and returns just after a rising edge.
  task automatic send(input logic [BW-1:0] n, input logic [BW-1:0] w, input logic [1:0] c);
    bit done;
    done   = 1'b0;
    neuron = n;
    weight = w;
    ctl    = c;
    vld_i  = 1'b1;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (rdy_i) begin
        apply_model(n, w, c);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    vld_i = 1'b0;
    n_checks++;
    if (!done) begin
      n_errors++;
      $display("FAIL send_accept: beat not accepted within 200 cycles (rdy_i=%b, required 1)", rdy_i);
    end
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (got_q.size() >= exp_q.size()) break;
    end
    repeat (6) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if (vld_o !== 1'b0) begin n_errors++; $display("FAIL reset_vld_o got=%b exp=0", vld_o); end
    n_checks++;
    if (sat_o !== 1'b0) begin n_errors++; $display("FAIL reset_sat_o got=%b exp=0", sat_o); end
    n_checks++;
    if (rdy_i !== 1'b1) begin n_errors++; $display("FAIL reset_rdy_i got=%b exp=1", rdy_i); end
    n_checks++;
    if (result !== '0) begin n_errors++; $display("FAIL reset_result got=%0d exp=0", result); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    logic [BW-1:0] n, w;
    int s;
    s = got_q.size();
    for (int i = 0; i < LANES; i++) begin
      n[i*DW +: DW] = DW'(i + 1);
      w[i*DW +: DW] = DW'(i + 5);
    end
    send(n, w, 2'b11);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (vld_o !== (k == 2)) begin
        n_errors++;
        $display("FAIL single_latency edge %0d after accept: vld_o got=%b exp=%b", k + 1, vld_o, (k == 2));
      end
    end
    n_checks++;
    if (result !== 32'd70) begin n_errors++; $display("FAIL single_result got=%0d exp=70", $signed(result)); end
    @(posedge clk);
    #1;
    wait_drain();
    n_checks++;
    if (got_at(s) !== {32'd70, 1'b0}) begin
      n_errors++;
      $display("FAIL single_xfer got=%h exp=%h", got_at(s), {32'd70, 1'b0});
    end
  endtask

  task automatic test_back_to_back();
    int s;
    logic [AW-1:0] e;
    s = got_q.size();
    send(splat(100), splat(-3), 2'b01);
    send(splat(100), splat(-3), 2'b00);
    send(splat(100), splat(-3), 2'b10);
    send(splat(1), splat(1), 2'b11);
    wait_drain();
    e = -3600;
    n_checks++;
    if (got_at(s) !== {e, 1'b0}) begin
      n_errors++;
      $display("FAIL multi_accum got=%h exp=%h", got_at(s), {e, 1'b0});
    end
    n_checks++;
    if (got_at(s + 1) !== {32'd4, 1'b0}) begin
      n_errors++;
      $display("FAIL b2b_result got=%h exp=%h", got_at(s + 1), {32'd4, 1'b0});
    end
    n_checks++;
    if (got_cyc.size() < s + 2 || got_cyc[s + 1] - got_cyc[s] != 1) begin
      n_errors++;
      $display("FAIL b2b_spacing got_results=%0d exp=%0d consecutive", got_cyc.size() - s, 2);
    end
  endtask

  task automatic test_backpressure();
    int s;
    logic [AW-1:0] e;
    s = got_q.size();
    rdy_mode = 1;
    send(splat(7), splat(9), 2'b01);
    send(splat(-2), splat(5), 2'b10);
    send(splat(3), splat(3), 2'b01);
    send(splat(3), splat(3), 2'b10);
    fork
      send(splat(-1), splat(4), 2'b11);
      begin : chk_b
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 30 && !seen; k++) begin
          @(negedge clk);
          if (vld_o) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin n_errors++; $display("FAIL bp_vld_o got=0 exp=1 within 30 cycles"); end
        for (int k = 0; k < 5; k++) begin
          n_checks++;
          if (vld_o !== 1'b1 || rdy_i !== 1'b0 || result !== 32'd212) begin
            n_errors++;
            $display("FAIL bp_hold cycle %0d: vld_o=%b rdy_i=%b result=%0d exp vld_o=1 rdy_i=0 result=212",
                     k, vld_o, rdy_i, $signed(result));
          end
          @(negedge clk);
        end
        @(posedge clk);
        #1;
        rdy_mode = 0;
      end
    join
    wait_drain();
    n_checks++;
    if (got_at(s) !== {32'd212, 1'b0}) begin
      n_errors++; $display("FAIL bp_first got=%h exp=%h", got_at(s), {32'd212, 1'b0});
    end
    n_checks++;
    if (got_at(s + 1) !== {32'd72, 1'b0}) begin
      n_errors++; $display("FAIL bp_second got=%h exp=%h", got_at(s + 1), {32'd72, 1'b0});
    end
    e = -16;
    n_checks++;
    if (got_at(s + 2) !== {e, 1'b0}) begin
      n_errors++; $display("FAIL bp_stalled_beat got=%h exp=%h", got_at(s + 2), {e, 1'b0});
    end
  endtask

  task automatic test_reset_mid();
    int keep;
    logic [AW-1:0] e;
    keep = exp_q.size();
    send(splat(5), splat(5), 2'b11);
    send(splat(6), splat(6), 2'b11);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    while (exp_q.size() > keep) void'(exp_q.pop_back());
    m_acc = 0;
    m_sat = 1'b0;
    @(negedge clk);
    n_checks++;
    if (vld_o !== 1'b0) begin n_errors++; $display("FAIL midrst_vld_o got=%b exp=0", vld_o); end
    n_checks++;
    if (sat_o !== 1'b0) begin n_errors++; $display("FAIL midrst_sat_o got=%b exp=0", sat_o); end
    n_checks++;
    if (rdy_i !== 1'b1) begin n_errors++; $display("FAIL midrst_rdy_i got=%b exp=1", rdy_i); end
    repeat (5) @(negedge clk);
    n_checks++;
    if (got_q.size() != keep) begin
      n_errors++; $display("FAIL midrst_discard results got=%0d exp=%0d", got_q.size(), keep);
    end
    @(posedge clk);
    #1;
    send(splat(2), splat(-3), 2'b11);
    wait_drain();
    e = -24;
    n_checks++;
    if (got_at(keep) !== {e, 1'b0}) begin
      n_errors++; $display("FAIL midrst_new got=%h exp=%h", got_at(keep), {e, 1'b0});
    end
  endtask

  task automatic test_wrap_sat();
    int s;
    logic [AW:0] e;
    s = got_q.size();
    send(splat(32767), splat(32767), 2'b01);
    send(splat(32767), splat(32767), 2'b00);
    send(splat(32767), splat(32767), 2'b00);
    send(splat(32767), splat(32767), 2'b10);
    send(splat(1), splat(1), 2'b11);
    wait_drain();
`ifdef VECTOR_MAC_PE_SAT_EN
    e = {32'h7FFF_FFFF, 1'b1};
`else
    e = {32'hFFF0_0010, 1'b0};
`endif
    n_checks++;
    if (got_at(s) !== e) begin
      n_errors++; $display("FAIL overflow_result got=%h exp=%h", got_at(s), e);
    end
    n_checks++;
    if (got_at(s + 1) !== {32'd4, 1'b0}) begin
      n_errors++; $display("FAIL sat_cleared got=%h exp=%h", got_at(s + 1), {32'd4, 1'b0});
    end
  endtask

  task automatic test_random();
    int s;
    s = exp_q.size();
    rdy_mode = 2;
    for (int b = 0; b < 300; b++) begin
      send({$urandom(), $urandom()}, {$urandom(), $urandom()}, 2'($urandom_range(0, 3)));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rdy_mode = 0;
    wait_drain();
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_errors++; $display("FAIL rand_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    for (int i = s; i < exp_q.size(); i++) begin
      n_checks++;
      if (got_at(i) !== exp_q[i]) begin
        n_errors++; $display("FAIL rand_result idx %0d got=%h exp=%h", i, got_at(i), exp_q[i]);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_wrap_sat();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
